// File: rtl/baby_cycle_sequencer_if.sv
// Front-panel controls and beat-enable outputs of the Baby cycle sequencer.
// The panel/decoder side uses master; the sequencer uses slave.
interface baby_cycle_sequencer_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   RUN;
  logic                   STEP;
  logic                   STOP;
  logic                   FETCH;
  logic                   DECODE;
  logic                   EXECUTE;
  logic                   WRITEBACK;
  logic                   BEAT_STROBE;
  logic                   BUSY;
  logic                   HALTED;
  logic [COUNT_WIDTH-1:0] INSTR_COUNT;

  modport master (
    output RUN, STEP, STOP,
    input  FETCH, DECODE, EXECUTE, WRITEBACK, BEAT_STROBE, BUSY, HALTED, INSTR_COUNT
  );

  modport slave (
    input  RUN, STEP, STOP,
    output FETCH, DECODE, EXECUTE, WRITEBACK, BEAT_STROBE, BUSY, HALTED, INSTR_COUNT
  );
endinterface

// File: rtl/baby_cycle_sequencer.sv
// Baby cycle sequencer: FETCH/DECODE/EXECUTE/WRITEBACK beats of BEAT_CLOCKS clocks each.
// Optional instruction counter enabled by defining SEQUENCER_INSTR_COUNT_EN.
module baby_cycle_sequencer #(
  parameter int PROPAGATION_DELAY = 12,
  parameter int BEAT_CLOCKS       = 4,
  parameter int COUNT_WIDTH       = 8
) (
  input logic                  CLK,
  input logic                  CLR_n,
  baby_cycle_sequencer_if.slave bus
);
  localparam int CW = $clog2(BEAT_CLOCKS);
  localparam logic [CW-1:0] LAST = CW'(BEAT_CLOCKS - 1);

  if (BEAT_CLOCKS < 2 || BEAT_CLOCKS > 16 || PROPAGATION_DELAY < 0) begin : g_bad_param
    $error("baby_cycle_sequencer: BEAT_CLOCKS must be 2..16");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          stop_q, stop_d;
  logic          step_prev_q;
  logic          beat, terminal, wb_done, step_rise;

  assign beat      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign terminal  = beat && (cnt_q == LAST);
  assign wb_done   = (state_q == S_WRITEBACK) && terminal;
  assign step_rise = bus.STEP && !step_prev_q;

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      stop_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      stop_q      <= stop_d;
      step_prev_q <= bus.STEP;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    if (beat) cnt_d = terminal ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      S_IDLE:      if (bus.RUN || step_q) state_d = S_FETCH;
      S_FETCH:     if (terminal) state_d = S_DECODE;
      S_DECODE:    if (terminal) state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (bus.STOP) stop_d = 1'b1;
        if (terminal) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: if (terminal) begin
        if (stop_q) begin
          state_d = S_HALT;
          stop_d  = 1'b0;
        end else if (bus.RUN || step_q) state_d = S_FETCH;
        else state_d = S_IDLE;
      end
      S_HALT:      if (!bus.RUN && !bus.STEP) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // A fresh STEP edge on the same clock as a service still counts as a new request.
    step_d = ((state_d == S_FETCH && state_q != S_FETCH) ? 1'b0 : step_q) |
             (step_rise && !bus.RUN);
  end

  always_comb begin
    bus.FETCH       = (state_q == S_FETCH);
    bus.DECODE      = (state_q == S_DECODE);
    bus.EXECUTE     = (state_q == S_EXECUTE);
    bus.WRITEBACK   = (state_q == S_WRITEBACK);
    bus.BEAT_STROBE = beat && (cnt_q == '0);
    bus.BUSY        = beat;
    bus.HALTED      = (state_q == S_HALT);
  end

`ifdef SEQUENCER_INSTR_COUNT_EN
  logic [COUNT_WIDTH-1:0] icnt_q;

  always_ff @(posedge CLK) begin
    if (!CLR_n)       icnt_q <= '0;
    else if (wb_done) icnt_q <= icnt_q + COUNT_WIDTH'(1);
  end

  assign bus.INSTR_COUNT = icnt_q;
`else
  assign bus.INSTR_COUNT = '0;
`endif
endmodule

// File: tb/tb_baby_cycle_sequencer.sv
// Directed bench for baby_cycle_sequencer; a second COUNT_WIDTH=2 instance checks counter wrap.
module tb_baby_cycle_sequencer;
  logic clk = 1'b0;
  logic clr_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  baby_cycle_sequencer_if #(.COUNT_WIDTH(8)) bus ();
  baby_cycle_sequencer_if #(.COUNT_WIDTH(2)) bus2 ();

  assign bus2.RUN  = bus.RUN;
  assign bus2.STEP = bus.STEP;
  assign bus2.STOP = bus.STOP;

  baby_cycle_sequencer #(.PROPAGATION_DELAY(12), .BEAT_CLOCKS(4), .COUNT_WIDTH(8)) u_dut (
    .CLK(clk), .CLR_n(clr_n), .bus(bus)
  );

  baby_cycle_sequencer #(.PROPAGATION_DELAY(12), .BEAT_CLOCKS(4), .COUNT_WIDTH(2)) u_dut2 (
    .CLK(clk), .CLR_n(clr_n), .bus(bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // st: 0 idle, 1 F, 2 D, 3 E, 4 W, 5 halt; c: instructions completed so far
  task automatic chk(input string tag, input int st, input bit sb, input int c);
    logic [6:0] obs, exp;
    logic [7:0] oc, ec;
    logic [1:0] oc2, ec2;
    obs = {bus.FETCH, bus.DECODE, bus.EXECUTE, bus.WRITEBACK, bus.BEAT_STROBE, bus.BUSY, bus.HALTED};
    exp = {st == 1, st == 2, st == 3, st == 4, sb, (st >= 1 && st <= 4), st == 5};
`ifdef SEQUENCER_INSTR_COUNT_EN
    ec  = 8'(c);
    ec2 = 2'(c);
`else
    ec  = '0;
    ec2 = '0;
`endif
    oc  = bus.INSTR_COUNT;
    oc2 = bus2.INSTR_COUNT;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s beats obs=%b exp=%b", tag, obs, exp);
    end
    total++;
    assert (oc === ec) else begin
      bad++;
      $error("FAIL %s count obs=%0d exp=%0d", tag, oc, ec);
    end
    total++;
    assert (oc2 === ec2) else begin
      bad++;
      $error("FAIL %s count_w2 obs=%0d exp=%0d", tag, oc2, ec2);
    end
  endtask

  // One F/D/E/W pass. After the check at index i: RUN drops at run_off,
  // STEP/STOP take mask bit i, and reset asserts at abort_at.
  task automatic pass(input int c, input int run_off, input logic [15:0] step_m,
                      input logic [15:0] stop_m, input int abort_at);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("pass%0d_%0d", c, i), 1 + i / 4, (i % 4) == 0, c);
      if (i == run_off) bus.RUN = 1'b0;
      bus.STEP = step_m[i];
      bus.STOP = stop_m[i];
      if (i == abort_at) begin
        clr_n = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    clr_n    = 1'b0;
    bus.RUN  = 1'b1;
    bus.STEP = 1'b0;
    bus.STOP = 1'b0;

    // reset held 2 clocks with RUN=1
    tick(); chk("rst0", 0, 0, 0);
    tick(); chk("rst1", 0, 0, 0);

    // free run for 40 clocks, then RUN drops mid-DECODE of the third instruction
    clr_n = 1'b1;
    pass(0, -1, 16'h0, 16'h0, -1);
    pass(1, -1, 16'h0, 16'h0, -1);
    pass(2, 7, 16'h0, 16'h0, -1);
    tick(); chk("run_drop_idle0", 0, 0, 3);
    tick(); chk("run_drop_idle1", 0, 0, 3);

    // single step; three extra STEP pulses collapse into one more instruction
    bus.STEP = 1'b1;
    tick(); chk("step_latch", 0, 0, 3);
    bus.STEP = 1'b0;
    pass(3, -1, 16'b0000_0100_0100_0100, 16'h0, -1);
    pass(4, -1, 16'h0, 16'h0, -1);
    tick(); chk("step_done0", 0, 0, 5);
    tick(); chk("step_done1", 0, 0, 5);

    // STOP in DECODE ignored, STOP in EXECUTE halts after writeback
    bus.RUN = 1'b1;
    pass(5, -1, 16'h0, 16'b0000_0000_0010_0000, -1);
    pass(6, -1, 16'h0, 16'b0000_0010_0000_0000, -1);
    tick(); chk("halt0", 5, 0, 7);
    tick(); chk("halt1", 5, 0, 7);
    tick(); chk("halt2", 5, 0, 7);
    bus.RUN = 1'b0;
    tick(); chk("halt_release", 0, 0, 7);
    bus.RUN = 1'b1;
    pass(7, -1, 16'h0, 16'h0, -1);

    // reset mid-EXECUTE aborts with nothing counted
    pass(8, -1, 16'h0, 16'h0, 9);
    tick(); chk("abort_idle", 0, 0, 0);
    clr_n = 1'b1;
    pass(0, 3, 16'h0, 16'h0, -1);
    tick(); chk("final_idle", 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
